fpmul_arbiter: RTL

Shares one iterative `fpmul` unit among `N_REQ` requesters. Each requester offers an operand pair over a valid/ready handshake. A round-robin grant picks one requester, and the block sequences the multiplier's `start`/`ready` protocol. The tagged result is returned on a single response channel. The block sits between the scalar issue logic and the shared FP multiply datapath.

---
 rtl/fpmul_arb_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/fpmul_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/fpmul_arb_pkg.sv
// rtl/fpmul_arb_pkg.sv - shared types for the fpmul request arbiter
package fpmul_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_BIT = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [ID_BIT-1:0] ptr,
  output logic [N_REQ-1:0]  grant,
  output logic [ID_BIT-1:0] grant_idx,
  output logic              any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    // Scan upward from ptr with wrap-around; the first hit wins.
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_BIT'(idx);
      end
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// rtl/fpmul_arbiter.sv - shares one iterative fpmul among N_REQ requesters
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int LOG_BIT = 5,
  parameter int N_BIT   = 1 << LOG_BIT,
  parameter int N_REQ   = 4,
  parameter int ID_BIT  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][N_BIT-1:0] req_a,
  input  logic [N_REQ-1:0][N_BIT-1:0] req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_BIT-1:0]           rsp_id,
  output logic [N_BIT-1:0]            rsp_data,
  output logic                        mul_start,
  output logic [N_BIT-1:0]            mul_a,
  output logic [N_BIT-1:0]            mul_b,
  input  logic [N_BIT-1:0]            mul_out,
  input  logic                        mul_ready
);

  arb_state_t          state;
  logic [ID_BIT-1:0]   ptr;
  logic [N_REQ-1:0]    grant;
  logic [ID_BIT-1:0]   grant_idx;
  logic                grant_any;

  rr_arbiter #(
    .N_REQ  (N_REQ),
    .ID_BIT (ID_BIT)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Grant is only visible while idle, so pending results backpressure everyone.
  assign req_ready = (state == IDLE) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            mul_a     <= req_a[grant_idx];
            mul_b     <= req_b[grant_idx];
            rsp_id    <= grant_idx;
            ptr       <= (grant_idx == ID_BIT'(N_REQ - 1)) ? '0 : grant_idx + ID_BIT'(1);
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // mul_ready is only trusted here; a stale level during ISSUE is ignored.
          if (mul_ready) begin
            rsp_data  <= mul_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
